// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_HOLD
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_TRAP,
        SEL_MRET
    } pc_sel_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - priority next-PC select with branch/jump alignment check
import riscv_pkg::*;

module next_pc_mux (
    input  logic [31:0] pc,
    input  logic        trap_taken,
    input  logic [31:0] trap_addr,
    input  logic        mret,
    input  logic [31:0] epc,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jalr,
    input  logic [31:0] iaddr,
    output pc_sel_t     sel,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] br_target;

    // jalr only qualifies a jump; a plain taken branch uses iaddr untouched
    always_comb begin
        br_target = iaddr;
        if (jump && jalr) begin
            br_target[0] = 1'b0;
        end
    end

    always_comb begin
        sel        = SEL_SEQ;
        next_pc    = pc + 32'd4;
        misaligned = 1'b0;
        if (trap_taken) begin
            sel     = SEL_TRAP;
            next_pc = {trap_addr[31:2], 2'b00};
        end else if (mret) begin
            sel     = SEL_MRET;
            next_pc = {epc[31:2], 2'b00};
        end else if (branch_taken || jump) begin
            sel        = SEL_BR;
            next_pc    = br_target;
            misaligned = (br_target[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and instruction fetch handshake
import riscv_pkg::*;

module pc_fetch_unit #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic        jump_in,
    input  logic        jalr_in,
    input  logic [31:0] iaddr_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_addr_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        imem_ack_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        instr_valid_out,
    output logic        misaligned_out
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  pc_out_nxt, instr_nxt;
    logic         valid_nxt, mis_nxt;

    pc_sel_t      sel;
    logic [31:0]  mux_pc;
    logic         mux_mis;

    next_pc_mux u_next_pc_mux (
        .pc           (pc),
        .trap_taken   (trap_taken_in),
        .trap_addr    (trap_addr_in),
        .mret         (mret_in),
        .epc          (epc_in),
        .branch_taken (branch_taken_in),
        .jump         (jump_in),
        .jalr         (jalr_in),
        .iaddr        (iaddr_in),
        .sel          (sel),
        .next_pc      (mux_pc),
        .misaligned   (mux_mis)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= ST_BOOT;
            pc              <= BOOT_ADDR;
            pc_out          <= BOOT_ADDR;
            instr_out       <= NOP_INSTR;
            instr_valid_out <= 1'b0;
            misaligned_out  <= 1'b0;
        end else begin
            state           <= state_nxt;
            pc              <= pc_nxt;
            pc_out          <= pc_out_nxt;
            instr_out       <= instr_nxt;
            instr_valid_out <= valid_nxt;
            misaligned_out  <= mis_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        pc_out_nxt = pc_out;
        instr_nxt  = instr_out;
        valid_nxt  = instr_valid_out;
        mis_nxt    = 1'b0;
        case (state)
            ST_BOOT: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH, ST_HOLD: begin
                if (sel != SEL_SEQ) begin
                    // any redirect drops a same-cycle ack and overrides stall
                    state_nxt = ST_FETCH;
                    valid_nxt = 1'b0;
                    if (mux_mis) begin
                        mis_nxt = 1'b1;
                    end else begin
                        pc_nxt    = mux_pc;
                        instr_nxt = NOP_INSTR;
                    end
                end else if (state == ST_FETCH) begin
                    if (imem_ack_in) begin
                        instr_nxt  = imem_rdata_in;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = mux_pc;
                        state_nxt  = stall_in ? ST_HOLD : ST_FETCH;
                    end else if (!stall_in) begin
                        valid_nxt = 1'b0;
                    end
                end else if (!stall_in) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_BOOT;
            end
        endcase
    end

    assign imem_req_out  = (state == ST_FETCH);
    assign imem_addr_out = pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks against a behavioural fetch model
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, br = 1'b0, jmp = 1'b0, jalr = 1'b0;
    logic        trap = 1'b0, mret = 1'b0, ack = 1'b0;
    logic [31:0] iaddr = '0, taddr = '0, epc = '0, rdata = '0;
    logic        req, valid, mis;
    logic [31:0] addr, pco, instr;

    int vectors = 0;
    int miscompares = 0;

    // model: "waiting" = one idle cycle after reset, "parked" = stalled after a capture
    bit          m_waiting, m_parked, m_valid, m_mis;
    logic [31:0] m_pc, m_pco, m_instr;

    pc_fetch_unit dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .stall_in        (stall),
        .branch_taken_in (br),
        .jump_in         (jmp),
        .jalr_in         (jalr),
        .iaddr_in        (iaddr),
        .trap_taken_in   (trap),
        .trap_addr_in    (taddr),
        .mret_in         (mret),
        .epc_in          (epc),
        .imem_rdata_in   (rdata),
        .imem_ack_in     (ack),
        .imem_req_out    (req),
        .imem_addr_out   (addr),
        .pc_out          (pco),
        .instr_out       (instr),
        .instr_valid_out (valid),
        .misaligned_out  (mis)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_waiting = 1; m_parked = 0; m_valid = 0; m_mis = 0;
        m_pc = 32'h0; m_pco = 32'h0; m_instr = NOP;
    endtask

    task automatic model_cycle();
        logic [31:0] t;
        m_mis = 0;
        if (m_waiting) begin
            m_waiting = 0;
        end else if (trap || mret) begin
            m_pc     = (trap ? taddr : epc) & 32'hFFFF_FFFC;
            m_valid  = 0;
            m_instr  = NOP;
            m_parked = 0;
        end else if (br || jmp) begin
            t = (jmp && jalr) ? (iaddr & 32'hFFFF_FFFE) : iaddr;
            m_valid  = 0;
            m_parked = 0;
            if (t % 4 != 0) begin
                m_mis = 1;
            end else begin
                m_pc    = t;
                m_instr = NOP;
            end
        end else if (m_parked) begin
            if (!stall) m_parked = 0;
        end else if (ack) begin
            m_instr  = rdata;
            m_pco    = m_pc;
            m_valid  = 1;
            m_pc     = m_pc + 32'd4;
            m_parked = stall;
        end else if (!stall) begin
            m_valid = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".req"},   {31'b0, req},   {31'b0, !m_waiting && !m_parked});
        chk({tag, ".addr"},  addr,           m_pc);
        chk({tag, ".pc"},    pco,            m_pco);
        chk({tag, ".instr"}, instr,          m_instr);
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, m_valid});
        chk({tag, ".mis"},   {31'b0, mis},   {31'b0, m_mis});
    endtask

    task automatic step(input string tag);
        if (rst) model_reset(); else model_cycle();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clr();
        stall = 0; br = 0; jmp = 0; jalr = 0; trap = 0; mret = 0; ack = 0;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset.req",   {31'b0, req},   32'd0);
        chk("reset.pc",    pco,            32'h0);
        chk("reset.instr", instr,          NOP);
        chk("reset.valid", {31'b0, valid}, 32'd0);
        rst = 0;

        // sequential fetch with ack every cycle, rdata = addr|1
        ack = 1; rdata = m_pc | 32'd1;
        step("boot");
        chk("first_req", {31'b0, req}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            rdata = m_pc | 32'd1;
            step("seq");
        end
        chk("seq_pc4", pco, 32'h4);
        chk("seq_instr5", instr, 32'h5);

        // ack at pc=8 while stalled, then hold for two more cycles
        stall = 1; rdata = m_pc | 32'd1;
        step("stall_ack");
        ack = 0;
        for (int i = 0; i < 2; i++) step("hold");
        chk("hold_instr", instr, 32'h9);
        chk("hold_req", {31'b0, req}, 32'd0);
        stall = 0;
        step("release");
        chk("release_addr", addr, 32'hC);

        // branch with same-cycle ack: ack data dropped
        br = 1; iaddr = 32'h100; ack = 1; rdata = 32'hDEAD_BEEF;
        step("branch");
        chk("branch_addr", addr, 32'h100);
        chk("branch_instr", instr, NOP);
        clr();

        jmp = 1; jalr = 1; iaddr = 32'h201;
        step("jalr");
        chk("jalr_addr", addr, 32'h200);
        jalr = 0; iaddr = 32'h202;
        step("misalign");
        chk("misalign_pulse", {31'b0, mis}, 32'd1);
        chk("misalign_pc", addr, 32'h200);
        clr();
        step("misalign_end");
        chk("misalign_gone", {31'b0, mis}, 32'd0);

        trap = 1; taddr = 32'h80; br = 1; iaddr = 32'h100;
        step("trap");
        chk("trap_addr", addr, 32'h80);
        clr(); mret = 1; epc = 32'h1007;
        step("mret");
        chk("mret_addr", addr, 32'h1004);
        clr();

        // wrap at top of address space
        jmp = 1; iaddr = 32'hFFFF_FFFC;
        step("to_top");
        clr(); ack = 1; rdata = 32'h1234_5678;
        step("wrap");
        chk("wrap_addr", addr, 32'h0);
        chk("wrap_pc", pco, 32'hFFFF_FFFC);

        // asynchronous reset mid-fetch, then a stray ack during the boot cycle
        @(posedge clk); #3;
        rst = 1;
        #1;
        model_reset();
        chk("arst_req",   {31'b0, req},   32'd0);
        chk("arst_valid", {31'b0, valid}, 32'd0);
        chk("arst_pc",    pco,            32'h0);
        @(negedge clk);
        rst = 0; ack = 1; rdata = 32'hBAD0_0001;
        step("stray_ack");
        rdata = 32'h0000_0AA1;
        step("post_reset");

        for (int i = 0; i < 500; i++) begin
            logic [31:0] mask;
            clr();
            ack   = ($urandom_range(0, 1) == 1);
            stall = ($urandom_range(0, 3) == 0);
            rdata = $urandom;
            mask  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
            iaddr = $urandom & mask;
            taddr = $urandom;
            epc   = $urandom;
            br    = ($urandom_range(0, 15) == 0);
            jmp   = ($urandom_range(0, 15) == 0);
            jalr  = ($urandom_range(0, 1) == 1);
            trap  = ($urandom_range(0, 31) == 0);
            mret  = ($urandom_range(0, 31) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the architectural program counter and issues instruction-memory fetch requests over a req/ack handshake.
- Latches the returned instruction together with its PC for decode.
- Selects the next PC from four sources: sequential PC+4, branch/jump target (iaddr_in, produced by immediate_adder), trap vector, or mret return address.
- Sits directly downstream of immediate_adder and upstream of decode.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_out when flushed or after reset (addi x0,x0,0).

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  asynchronous, active-high reset
- stall_in  input  1  downstream not ready; hold current instruction, issue no new fetch
- branch_taken_in  input  1  conditional branch resolved taken; redirect to iaddr_in
- jump_in  input  1  JAL/JALR; redirect to iaddr_in
- jalr_in  input  1  qualifies jump_in; clear bit 0 of target before use
- iaddr_in  input  32  branch/jump target from immediate_adder
- trap_taken_in  input  1  redirect to trap_addr_in
- trap_addr_in  input  32  trap vector
- mret_in  input  1  redirect to epc_in
- epc_in  input  32  exception return PC
- imem_rdata_in  input  32  fetched instruction word
- imem_ack_in  input  1  imem_rdata_in valid this cycle for the outstanding request
- imem_req_out  output  1  fetch request
- imem_addr_out  output  32  fetch address; equals current PC register
- pc_out  output  32  PC of instr_out
- instr_out  output  32  fetched instruction
- instr_valid_out  output  1  instr_out/pc_out valid for decode
- misaligned_out  output  1  one-cycle pulse: branch/jump target not word-aligned

Behaviour:
- Reset (async, any time including mid-fetch):
  - pc=BOOT_ADDR, state=BOOT, imem_req_out=0
  - pc_out=BOOT_ADDR, instr_out=NOP_INSTR, instr_valid_out=0, misaligned_out=0
  - An in-flight ack arriving after reset release is ignored unless the state is FETCH.
- States:
  - BOOT: req=0. Next cycle -> FETCH.
  - FETCH: req=1, imem_addr_out=pc.
    - On ack with no redirect and stall_in=0: instr_out<=rdata, pc_out<=pc, instr_valid_out<=1, pc<=pc+4 (mod 2^32; wraps 32'hFFFF_FFFC -> 0). Stay in FETCH, so back-to-back fetches give one instruction per ack.
    - On ack with stall_in=1: the fetched word is still captured (same updates) and the state goes to HOLD.
    - No ack: instr_valid_out<=0 unless stall_in=1, in which case it is held.
  - HOLD: req=0. instr_out, pc_out and instr_valid_out are held. When stall_in falls -> FETCH.
- Stall when valid and no ack in FETCH: instr_valid_out and instr_out are held; req stays asserted.
- Redirect priority: trap_taken_in > mret_in > (branch_taken_in | jump_in) > stall/sequential.
- Redirect in any non-BOOT state:
  - Target is selected; for jalr_in&jump_in, bit 0 is cleared.
  - Trap and mret targets have bits [1:0] forced to 0.
  - pc<=target, instr_valid_out<=0, instr_out<=NOP_INSTR, state<=FETCH.
  - An ack in the same cycle is discarded. Redirect overrides stall.
- Misaligned branch/jump (final target[1:0]!=0, with no trap/mret the same cycle):
  - pc is not updated; misaligned_out=1 for exactly one cycle; instr_valid_out<=0; state<=FETCH, re-fetching the held pc.
  - The trap unit is expected to respond with trap_taken_in.
- Simultaneous branch_taken_in and jump_in: same target (iaddr_in); jalr_in is only honoured with jump_in.
- Latency:
  - Reset release to first req: 1 cycle.
  - Ack to instr_valid_out: 1 cycle (registered).
  - Redirect to req at the new address: 1 cycle.

Decomposition:
- Shared package riscv_pkg:
  - state encoding (BOOT, FETCH, HOLD)
  - NOP constant 32'h0000_0013
  - next-PC select enum (SEQ, BR, TRAP, MRET)
- One natural sub-module: next_pc_mux, a combinational priority select plus alignment check producing next_pc and misaligned.
- State and registers stay in pc_fetch_unit.

Test Plan:
- Reset, BOOT_ADDR=0, ack every cycle with rdata=addr|1 -> req first at cycle 1. imem_addr_out sequence 0,4,8. pc_out/instr_out 0/1, 4/5, 8/9 one cycle after each ack.
- Ack with stall_in=1 for 3 cycles at pc=8 -> instr_out/pc_out held at 9/8, valid=1, req=0. Stall release -> req at addr 12.
- branch_taken_in with iaddr_in=0x100 and ack in the same cycle -> ack data dropped, valid=0, instr_out=0x13, next imem_addr_out=0x100.
- jump_in+jalr_in, iaddr_in=0x201 -> pc=0x200, no misaligned. jump_in, iaddr_in=0x202 -> misaligned_out pulse of 1 cycle, pc unchanged.
- trap_taken_in (trap_addr_in=0x80) together with branch_taken_in (0x100) -> pc=0x80. Then mret_in with epc_in=0x1007 -> pc=0x1004.
- Assert rst_in asynchronously mid-FETCH -> outputs reset immediately (req=0, valid=0, pc_out=BOOT_ADDR). PC 0xFFFF_FFFC + ack -> pc wraps to 0.
